// File: rtl/cache_data_ram.sv
// ----------------------------------------------------------------------------
// cache_data_ram
//   Single-port synchronous data store for the L1 cache data array. There is
//   one WIDTH-bit word per cache line and DEPTH lines. The address is
//   registered and the output is read combinationally from the registered
//   address, which gives the usual single-port block-RAM timing: one cycle of
//   read latency and new-data read-during-write.
//
//   Build option: CACHE_RAM_OUTREG_EN
//     When this macro is defined, an extra output register is placed on q and
//     addr_err, so read latency becomes two cycles. Write timing is the same
//     in both builds.
//
// Ports
//   clock     in   rising-edge clock for all state
//   reset_n   in   synchronous active-low reset; clears the array, addr_q
//                  and the output register
//   wren      in   write enable for the current address
//   address   in   [ADDR_W] line index; values >= DEPTH are out of range
//   data      in   [WIDTH] write data
//   q         out  [WIDTH] read data for the registered address (0 when out
//                  of range)
//   addr_err  out  high when the registered address is out of range
// ----------------------------------------------------------------------------

// One storage word. Writes are enabled by the top-level decoder.
module cache_data_word #(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             we,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clock) begin
      if (!reset_n)
         q <= '0;
      else if (we)
         q <= d;
   end

endmodule

module cache_data_ram #(
   parameter int WIDTH  = 8,
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 3
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              wren,
   input  logic [ADDR_W-1:0] address,
   input  logic [WIDTH-1:0]  data,
   output logic [WIDTH-1:0]  q,
   output logic              addr_err
);

   // The range check is one bit wider than the address, so DEPTH == 2**ADDR_W
   // still compares correctly.
   localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

   logic [ADDR_W-1:0]            addr_q;
   logic [DEPTH-1:0][WIDTH-1:0]  words;
   logic [DEPTH-1:0]             word_we;
   logic [WIDTH-1:0]             rd_data;
   logic                         rd_err;

   always_ff @(posedge clock) begin
      if (!reset_n)
         addr_q <= '0;
      else
         addr_q <= address;
   end

   // Decode against the full address, so an out-of-range index never aliases
   // onto a real line. The reset term sits inside each word.
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_word
         assign word_we[gi] = wren && (address == ADDR_W'(gi));

         cache_data_word #(.WIDTH(WIDTH)) u_word (
            .clock   (clock),
            .reset_n (reset_n),
            .we      (word_we[gi]),
            .d       (data),
            .q       (words[gi])
         );
      end
   endgenerate

   // Read mux driven by the registered address. Because it reads the updated
   // array, a same-address write shows the new data right after the edge.
   always_comb begin
      rd_data = '0;
      for (int i = 0; i < DEPTH; i++)
         if (addr_q == ADDR_W'(i))
            rd_data = words[i];
   end

   assign rd_err = ({1'b0, addr_q} >= DEPTH_X);

`ifdef CACHE_RAM_OUTREG_EN
   logic [WIDTH-1:0] q_r;
   logic             err_r;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         q_r   <= '0;
         err_r <= 1'b0;
      end else begin
         q_r   <= rd_data;
         err_r <= rd_err;
      end
   end

   assign q        = q_r;
   assign addr_err = err_r;
`else
   assign q        = rd_data;
   assign addr_err = rd_err;
`endif

endmodule

// File: tb/tb_cache_data_ram.sv
// ----------------------------------------------------------------------------
// tb_cache_data_ram
//   Bench for cache_data_ram. A line-level reference model (integer array plus
//   the last presented address) is compared with q and addr_err on every
//   falling edge. Directed sequences carry hand-computed literal expectations
//   that are checked read latency cycles after their address was presented.
//   The bench then runs a randomized phase with occasional resets.
// ----------------------------------------------------------------------------
module tb_cache_data_ram;

   localparam int WIDTH  = 8;
   localparam int DEPTH  = 4;
   localparam int ADDR_W = 3;
`ifdef CACHE_RAM_OUTREG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic              clock = 1'b0;
   logic              reset_n;
   logic              wren;
   logic [ADDR_W-1:0] address;
   logic [WIDTH-1:0]  data;
   logic [WIDTH-1:0]  q;
   logic              addr_err;

   int n_cmp = 0;
   int n_bad = 0;

   cache_data_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .wren     (wren),
      .address  (address),
      .data     (data),
      .q        (q),
      .addr_err (addr_err)
   );

   always #5 clock = ~clock;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int m_mem [DEPTH];
   int m_a;
   int m_oq;
   bit m_oe;
   bit started = 1'b0;

   function automatic int rd(input int a);
      return (a < DEPTH) ? m_mem[a] : 0;
   endfunction

   always @(posedge clock) begin
      if (reset_n === 1'b0) begin
         foreach (m_mem[i]) m_mem[i] = 0;
         m_a     = 0;
         m_oq    = 0;
         m_oe    = 1'b0;
         started = 1'b1;
      end else begin
         // Output-register view: what was readable just before this edge.
         m_oq = rd(m_a);
         m_oe = (m_a >= DEPTH);
         if (wren && int'(address) < DEPTH)
            m_mem[address] = int'(data);
         m_a = int'(address);
      end
   end

   always @(negedge clock) begin
      if (started) begin
`ifdef CACHE_RAM_OUTREG_EN
         chk("model_q",   int'(q),        m_oq);
         chk("model_err", int'(addr_err), int'(m_oe));
`else
         chk("model_q",   int'(q),        rd(m_a));
         chk("model_err", int'(addr_err), int'(m_a >= DEPTH));
`endif
      end
   end

   // ---------------- literal expectations ----------------
   typedef struct {
      bit              en;
      logic [WIDTH-1:0] eq;
      bit              ee;
      string           nm;
   } lit_t;

   lit_t lq [$];

   // Drives one cycle of inputs, then checks the literal whose read latency
   // has expired.
   task automatic cyc(input bit r, input bit w, input int a, input int d,
                      input bit en, input int eq, input bit ee, input string nm);
      lit_t t;
      reset_n = r;
      wren    = w;
      address = ADDR_W'(a);
      data    = WIDTH'(d);
      t.en = en;
      t.eq = WIDTH'(eq);
      t.ee = ee;
      t.nm = nm;
      lq.push_back(t);
      @(posedge clock);
      @(negedge clock);
      if (lq.size() >= LAT) begin
         t = lq.pop_front();
         if (t.en) begin
            chk({t.nm, "_q"},   int'(q),        int'(t.eq));
            chk({t.nm, "_err"}, int'(addr_err), int'(t.ee));
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0, 0, "idle");
   endtask

   initial begin
      reset_n = 1'b0;
      wren    = 1'b0;
      address = '0;
      data    = '0;

      // Initial reset, then load a nonzero word so the later reset is observable.
      cyc(0, 0, 0, 0, 0, 0, 0, "por");
      lq.delete();
      cyc(1, 1, 2, 'h77, 0, 0, 0, "pre_wr");
      cyc(1, 0, 2, 0, 1, 'h77, 0, "pre_rd");
      cyc(1, 0, 2, 0, 1, 'h77, 0, "pre_rd");

      // Reset while a write is presented: the write must be dropped.
      cyc(0, 1, 2, 'hAA, 0, 0, 0, "rst");
      lq.delete();
      chk("rst_q",   int'(q),        0);
      chk("rst_err", int'(addr_err), 0);
      for (int i = 0; i < DEPTH; i++) cyc(1, 0, i, 0, 1, 0, 0, "rst_rd");

      // Write/read.
      for (int i = 0; i < DEPTH; i++) cyc(1, 1, i, 'h11 * (i + 1), 1, 'h11 * (i + 1), 0, "wr");
      for (int i = DEPTH - 1; i >= 0; i--) cyc(1, 0, i, 0, 1, 'h11 * (i + 1), 0, "rd");

      // Read-during-write and hold.
      cyc(1, 1, 1, 'h5A, 1, 'h5A, 0, "rdw");
      cyc(1, 0, 1, 0, 1, 'h5A, 0, "hold");
      cyc(1, 0, 1, 0, 1, 'h5A, 0, "hold");

      // Out-of-range writes must not alias.
      for (int i = 0; i < DEPTH; i++) cyc(1, 1, i, 'h11 * (i + 1), 0, 0, 0, "preload");
      cyc(1, 1, 4, 'hFF, 1, 0, 1, "oor4");
      cyc(1, 1, 7, 'hFF, 1, 0, 1, "oor7");
      for (int i = 0; i < DEPTH; i++) cyc(1, 0, i, 0, 1, 'h11 * (i + 1), 0, "oor_rd");

      // Refill-style sequence: read old word, then overwrite it.
      cyc(1, 0, 2, 0, 1, 'h33, 0, "refill_old");
      cyc(1, 1, 2, 'hC3, 1, 'hC3, 0, "refill_new");
      idle(2);

      // Randomized traffic with occasional resets; the model checks every cycle.
      for (int i = 0; i < 600; i++) begin
         bit r;
         r = ($urandom_range(0, 39) != 0);
         cyc(r, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
             int'($urandom_range(0, 255)), 0, 0, 0, "rnd");
      end
      idle(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
